// File: rtl/multi_lane_decoder.sv
// Parallel 8b/10b decoder: per-lane symbol decode, running-disparity tracking,
// disparity/code violation flags and saturating per-lane error counters.
module multi_lane_decoder #(
  parameter int LANES   = 1,
  parameter int ERRCNTW = 8,
  parameter bit RD_INIT = 1'b0
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       BitRev,
  input  logic                       InvertDataIn,
  input  logic                       InValid,
  input  logic [10*LANES-1:0]        Input,
  input  logic                       ClrDisp,
  input  logic                       ClrCount,
  output logic [8*LANES-1:0]         Output,
  output logic [LANES-1:0]           Control,
  output logic                       OutValid,
  output logic [LANES-1:0]           DispErr,
  output logic [LANES-1:0]           CodeErr,
  output logic [LANES-1:0]           RunDisp,
  output logic [ERRCNTW*LANES-1:0]   ErrCount
);

  function automatic logic [2:0] ones6(input logic [5:0] x);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, x[i]};
    return n;
  endfunction

  // Argument is the sub-block in transmission order abcdei (a is the MSB here).
  function automatic logic [4:0] dec6(input logic [5:0] s);
    case (s)
      6'b100111, 6'b011000: dec6 = 5'd0;
      6'b011101, 6'b100010: dec6 = 5'd1;
      6'b101101, 6'b010010: dec6 = 5'd2;
      6'b110001:            dec6 = 5'd3;
      6'b110101, 6'b001010: dec6 = 5'd4;
      6'b101001:            dec6 = 5'd5;
      6'b011001:            dec6 = 5'd6;
      6'b111000, 6'b000111: dec6 = 5'd7;
      6'b111001, 6'b000110: dec6 = 5'd8;
      6'b100101:            dec6 = 5'd9;
      6'b010101:            dec6 = 5'd10;
      6'b110100:            dec6 = 5'd11;
      6'b001101:            dec6 = 5'd12;
      6'b101100:            dec6 = 5'd13;
      6'b011100:            dec6 = 5'd14;
      6'b010111, 6'b101000: dec6 = 5'd15;
      6'b011011, 6'b100100: dec6 = 5'd16;
      6'b100011:            dec6 = 5'd17;
      6'b010011:            dec6 = 5'd18;
      6'b110010:            dec6 = 5'd19;
      6'b001011:            dec6 = 5'd20;
      6'b101010:            dec6 = 5'd21;
      6'b011010:            dec6 = 5'd22;
      6'b111010, 6'b000101: dec6 = 5'd23;
      6'b110011, 6'b001100: dec6 = 5'd24;
      6'b100110:            dec6 = 5'd25;
      6'b010110:            dec6 = 5'd26;
      6'b110110, 6'b001001: dec6 = 5'd27;
      6'b001110, 6'b001111, 6'b110000: dec6 = 5'd28;
      6'b101110, 6'b010001: dec6 = 5'd29;
      6'b011110, 6'b100001: dec6 = 5'd30;
      6'b101011, 6'b010100: dec6 = 5'd31;
      default:              dec6 = 5'd0;
    endcase
  endfunction

  // Argument is fghj (f is the MSB here).
  function automatic logic [2:0] dec4(input logic [3:0] s);
    case (s)
      4'b1011, 4'b0100:                   dec4 = 3'd0;
      4'b1001:                            dec4 = 3'd1;
      4'b0101:                            dec4 = 3'd2;
      4'b1100, 4'b0011:                   dec4 = 3'd3;
      4'b1101, 4'b0010:                   dec4 = 3'd4;
      4'b1010:                            dec4 = 3'd5;
      4'b0110:                            dec4 = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dec4 = 3'd7;
      default:                            dec4 = 3'd0;
    endcase
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [9:0]         raw, v;
    logic [5:0]         s6;
    logic [3:0]         s4;
    logic [2:0]         n6, n4;
    logic               rd_q, rd6, rd_nxt, derr6, derr4, cerr_nxt, k_nxt;
    logic [7:0]         sym_nxt, sym_q;
    logic               k_q, derr_q, cerr_q;
    logic [ERRCNTW-1:0] cnt_q;

    assign raw = Input[10*l +: 10];

    always_comb begin
      v = raw;
      if (BitRev)
        for (int b = 0; b < 10; b++) v[b] = raw[9-b];
      if (InvertDataIn) v = ~v;
    end

    // NOTE: every always_comb output gets a default before any branch, so no latch can form.
    always_comb begin
      s6 = {v[0], v[1], v[2], v[3], v[4], v[5]};
      s4 = {v[6], v[7], v[8], v[9]};
      n6 = ones6(v[5:0]);
      n4 = ones6({2'b00, v[9:6]});

      derr6 = 1'b0;
      rd6   = rd_q;
      if (s6 == 6'b111000)      begin derr6 = ~rd_q; rd6 = 1'b0; end
      else if (s6 == 6'b000111) begin derr6 =  rd_q; rd6 = 1'b1; end
      else if (n6 == 3'd4)      begin derr6 =  rd_q; rd6 = 1'b1; end
      else if (n6 == 3'd2)      begin derr6 = ~rd_q; rd6 = 1'b0; end

      // The 4b sub-block is judged against the disparity left by the 6b sub-block.
      derr4  = 1'b0;
      rd_nxt = rd6;
      if (s4 == 4'b1100)      begin derr4 = ~rd6; rd_nxt = 1'b0; end
      else if (s4 == 4'b0011) begin derr4 =  rd6; rd_nxt = 1'b1; end
      else if (n4 == 3'd3)    begin derr4 =  rd6; rd_nxt = 1'b1; end
      else if (n4 == 3'd1)    begin derr4 = ~rd6; rd_nxt = 1'b0; end

      cerr_nxt = (n6 <= 3'd1) || (n6 >= 3'd5) || (n4 == 3'd0) || (n4 == 3'd4);

      k_nxt = (s6 == 6'b001111) || (s6 == 6'b110000) ||
              (((s4 == 4'b1000) || (s4 == 4'b0111)) &&
               (s6 inside {6'b111010, 6'b000101, 6'b110110, 6'b001001,
                           6'b101110, 6'b010001, 6'b011110, 6'b100001}));

      // K28 at RD+ carries its 4b sub-block complemented relative to RD-.
      sym_nxt = {dec4((s6 == 6'b110000) ? ~s4 : s4), dec6(s6)};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        sym_q  <= '0;
        k_q    <= 1'b0;
        derr_q <= 1'b0;
        cerr_q <= 1'b0;
        rd_q   <= RD_INIT;
        cnt_q  <= '0;
      end else begin
        if (InValid) begin
          sym_q  <= sym_nxt;
          k_q    <= k_nxt;
          derr_q <= derr6 | derr4;
          cerr_q <= cerr_nxt;
        end
        if (ClrDisp)      rd_q <= RD_INIT;
        else if (InValid) rd_q <= rd_nxt;
        if (ClrCount)
          cnt_q <= '0;
        else if (InValid && (derr6 || derr4 || cerr_nxt) && (cnt_q != '1))
          cnt_q <= cnt_q + 1'b1;
      end
    end

    assign Output[8*l +: 8]               = sym_q;
    assign Control[l]                     = k_q;
    assign DispErr[l]                     = derr_q;
    assign CodeErr[l]                     = cerr_q;
    assign RunDisp[l]                     = rd_q;
    assign ErrCount[ERRCNTW*l +: ERRCNTW] = cnt_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) OutValid <= 1'b0;
    else       OutValid <= InValid;
  end

endmodule
